// File: rtl/imm_patcher.sv
// Read-modify-write patcher: inserts a 32-bit immediate into an RV32I word in
// instruction RAM according to the word's own format. Nothing is written on error.
module imm_patcher #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_imm,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [31:0]   patched
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] E_OK    = 2'b00;
    localparam logic [1:0] E_OPC   = 2'b01;
    localparam logic [1:0] E_RANGE = 2'b10;
    localparam logic [1:0] E_ALIGN = 2'b11;

    state_t        state, state_nx;
    logic [AW-1:0] addr_q;
    logic [31:0]   imm_q;
    logic [31:0]   word_nx;
    logic [1:0]    code_nx;
    logic          accept;
    logic          fit12, fit13, fit21;

    assign accept = req_valid && req_ready;

    // An immediate fits in N signed bits when everything above bit N-1
    // is a copy of bit N-1.
    assign fit12 = (&imm_q[31:11]) || !(|imm_q[31:11]);
    assign fit13 = (&imm_q[31:12]) || !(|imm_q[31:12]);
    assign fit21 = (&imm_q[31:20]) || !(|imm_q[31:20]);

    // Format decode, checks and field insertion on the word returned by RAM.
    always_comb begin
        word_nx = mem_rdata;
        code_nx = E_OK;
        case (mem_rdata[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                if (!fit12) code_nx = E_RANGE;
                else        word_nx = {imm_q[11:0], mem_rdata[19:0]};
            end
            OP_STORE: begin
                if (!fit12) code_nx = E_RANGE;
                else        word_nx = {imm_q[11:5], mem_rdata[24:12],
                                       imm_q[4:0], mem_rdata[6:0]};
            end
            OP_BR: begin
                if (imm_q[0])    code_nx = E_ALIGN;
                else if (!fit13) code_nx = E_RANGE;
                else             word_nx = {imm_q[12], imm_q[10:5], mem_rdata[24:12],
                                            imm_q[4:1], imm_q[11], mem_rdata[6:0]};
            end
            OP_JAL: begin
                if (imm_q[0])    code_nx = E_ALIGN;
                else if (!fit21) code_nx = E_RANGE;
                else             word_nx = {imm_q[20], imm_q[10:1], imm_q[11],
                                            imm_q[19:12], mem_rdata[11:0]};
            end
            OP_LUI, OP_AUIPC: begin
                if (|imm_q[11:0]) code_nx = E_ALIGN;
                else              word_nx = {imm_q[31:12], mem_rdata[11:0]};
            end
            default: code_nx = E_OPC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_valid) state_nx = S_READ;
            S_READ:  state_nx = S_CAPT;
            S_CAPT:  state_nx = (code_nx != E_OK) ? S_DONE : S_WRITE;
            S_WRITE: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            imm_q    <= '0;
            err      <= 1'b0;
            err_code <= E_OK;
            patched  <= '0;
            done     <= 1'b0;
        end else begin
            // done is registered, so it rises the cycle after DONE while the
            // result fields stay put until the next request is taken.
            done <= (state == S_DONE);
            if (accept) begin
                addr_q   <= req_addr;
                imm_q    <= req_imm;
                err      <= 1'b0;
                err_code <= E_OK;
                patched  <= '0;
            end else if (state == S_CAPT) begin
                patched  <= word_nx;
                err      <= (code_nx != E_OK);
                err_code <= code_nx;
            end
        end
    end

    // RAM strobes are also gated by rst_n so a reset during WRITE kills the
    // strobe in the same cycle, independent of the state register.
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign mem_en    = rst_n && ((state == S_READ) || (state == S_WRITE));
    assign mem_we    = rst_n && (state == S_WRITE);
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_we ? patched : '0;

endmodule
